// File: rtl/clkgen_programmer_if.sv
// Request/status bundle between a host and clkgen_programmer.
// It also carries the DCM_CLKGEN PROGEN/PROGDATA/PROGDONE/LOCKED pins.
interface clkgen_programmer_if;
   logic [7:0] mul_i;
   logic [7:0] div_i;
   logic       load_i;
   logic       dcm_progdone_i;
   logic       dcm_locked_i;
   logic       dcm_progen_o;
   logic       dcm_progdata_o;
   logic       busy_o;
   logic       done_o;
   logic       error_o;
   logic [7:0] mul_o;
   logic [7:0] div_o;

   modport master (
      output mul_i, div_i, load_i, dcm_progdone_i, dcm_locked_i,
      input  dcm_progen_o, dcm_progdata_o, busy_o, done_o, error_o, mul_o, div_o
   );

   modport slave (
      input  mul_i, div_i, load_i, dcm_progdone_i, dcm_locked_i,
      output dcm_progen_o, dcm_progdata_o, busy_o, done_o, error_o, mul_o, div_o
   );
endinterface

// File: rtl/clkgen_programmer.sv
// Serial programmer for the Xilinx DCM_CLKGEN: shifts D then M over PROGEN/PROGDATA,
// issues GO, and waits for PROGDONE while LOCKED is high (bounded by TIMEOUT).
module clkgen_programmer #(
   parameter int TIMEOUT = 65535
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   clkgen_programmer_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE, LOAD_D, GAP_D, LOAD_M, GAP_M, GO, WAIT_DONE, FINISH
   } state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic [7:0]  mul_lat_q, mul_lat_d;
   logic [7:0]  div_lat_q, div_lat_d;
   logic        progen_q, progen_d;
   logic        progdata_q, progdata_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic [7:0]  mul_out_q, mul_out_d;
   logic [7:0]  div_out_q, div_out_d;
   logic [9:0]  d_frame;
   logic [9:0]  m_frame;

   // Each 10-bit word is sent bit 0 first: a two-bit command prefix, then the value LSB first.
   assign d_frame = {div_lat_q, 2'b01};
   assign m_frame = {mul_lat_q, 2'b11};

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      mul_lat_d  = mul_lat_q;
      div_lat_d  = div_lat_q;
      progen_d   = 1'b0;
      progdata_d = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      error_d    = error_q;
      mul_out_d  = mul_out_q;
      div_out_d  = div_out_q;

      case (state_q)
         IDLE: begin
            bit_cnt_d = '0;
            tmo_cnt_d = '0;
            if (bus.load_i) begin
               if (bus.mul_i != 8'd0) begin
                  mul_lat_d = bus.mul_i;
                  div_lat_d = bus.div_i;
                  error_d   = 1'b0;
                  busy_d    = 1'b1;
                  state_d   = LOAD_D;
               end else begin
                  error_d   = 1'b1;
               end
            end
         end
         LOAD_D: begin
            progen_d   = 1'b1;
            progdata_d = d_frame[bit_cnt_q];
            if (bit_cnt_q == 4'd9) begin
               bit_cnt_d = '0;
               state_d   = GAP_D;
            end else begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         GAP_D: begin
            if (bit_cnt_q == 4'd1) begin
               bit_cnt_d = '0;
               state_d   = LOAD_M;
            end else begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         LOAD_M: begin
            progen_d   = 1'b1;
            progdata_d = m_frame[bit_cnt_q];
            if (bit_cnt_q == 4'd9) begin
               bit_cnt_d = '0;
               state_d   = GAP_M;
            end else begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         GAP_M: begin
            if (bit_cnt_q == 4'd1) begin
               bit_cnt_d = '0;
               state_d   = GO;
            end else begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         GO: begin
            progen_d  = 1'b1;
            tmo_cnt_d = '0;
            state_d   = WAIT_DONE;
         end
         // Success results are registered on the way into FINISH so done_o lines up with it.
         WAIT_DONE: begin
            if (bus.dcm_progdone_i && bus.dcm_locked_i) begin
               done_d    = 1'b1;
               busy_d    = 1'b0;
               mul_out_d = mul_lat_q;
               div_out_d = div_lat_q;
               state_d   = FINISH;
            end else if (tmo_cnt_q == TMO_LAST) begin
               error_d   = 1'b1;
               busy_d    = 1'b0;
               tmo_cnt_d = '0;
               state_d   = IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         tmo_cnt_q  <= '0;
         mul_lat_q  <= 8'd1;
         div_lat_q  <= 8'd0;
         progen_q   <= 1'b0;
         progdata_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         mul_out_q  <= 8'd1;
         div_out_q  <= 8'd0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         mul_lat_q  <= mul_lat_d;
         div_lat_q  <= div_lat_d;
         progen_q   <= progen_d;
         progdata_q <= progdata_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         mul_out_q  <= mul_out_d;
         div_out_q  <= div_out_d;
      end
   end

   assign bus.dcm_progen_o   = progen_q;
   assign bus.dcm_progdata_o = progdata_q;
   assign bus.busy_o         = busy_q;
   assign bus.done_o         = done_q;
   assign bus.error_o        = error_q;
   assign bus.mul_o          = mul_out_q;
   assign bus.div_o          = div_out_q;

endmodule

// File: doc/clkgen_programmer.md
CLKGEN_PROGRAMMER -- requirements
Module: clkgen_programmer

Interface
REQ-001 Parameter TIMEOUT, default 65535: maximum clk_i cycles spent in WAIT_DONE before the block aborts.
REQ-002 clk_i  input  1  block clock; the same net drives DCM_CLKGEN PROGCLK outside this block.
REQ-003 reset_n_i  input  1  reset, asynchronous, active-low.
REQ-004 mul_i  input  8  requested multiply field, encoded M-1 (M = 2..256).
REQ-005 div_i  input  8  requested divide field, encoded D-1 (D = 1..256).
REQ-006 load_i  input  1  single-cycle request to program mul_i/div_i.
REQ-007 dcm_progdone_i  input  1  DCM_CLKGEN PROGDONE.
REQ-008 dcm_locked_i  input  1  DCM_CLKGEN locked qualifier (LOCKED & ~STATUS[2]).
REQ-009 dcm_progen_o  output  1  DCM_CLKGEN PROGEN.
REQ-010 dcm_progdata_o  output  1  DCM_CLKGEN PROGDATA.
REQ-011 busy_o  output  1  high while a programming sequence is in progress.
REQ-012 done_o  output  1  one-cycle pulse on successful completion.
REQ-013 error_o  output  1  sticky: set by timeout or an illegal request, cleared by the next accepted load_i.
REQ-014 mul_o  output  8  last successfully programmed M-1.
REQ-015 div_o  output  8  last successfully programmed D-1.

Function
REQ-016 FSM states: IDLE, LOAD_D, GAP_D, LOAD_M, GAP_M, GO, WAIT_DONE, FINISH.
REQ-017 In IDLE, load_i=1 with mul_i>=1: latch mul_i/div_i, clear error_o, set busy_o and go to LOAD_D on the next edge.
REQ-018 In IDLE, load_i=1 with mul_i=0 (M=1, illegal): set error_o, stay IDLE, leave dcm_progen_o low, leave mul_o/div_o unchanged.
REQ-019 load_i outside IDLE is ignored and the latched values are unaffected.
REQ-020 LOAD_D lasts 10 cycles with dcm_progen_o=1; dcm_progdata_o = 1, 0, then div bits 0..7, LSB first.
REQ-021 GAP_D and GAP_M each last 2 cycles with dcm_progen_o=0 and dcm_progdata_o=0.
REQ-022 LOAD_M lasts 10 cycles with dcm_progen_o=1; dcm_progdata_o = 1, 1, then mul bits 0..7, LSB first.
REQ-023 GO lasts 1 cycle with dcm_progen_o=1 and dcm_progdata_o=0.
REQ-024 Timing: load_i accepted at edge 0 puts the first PROGEN high at cycle 1 and GO at cycle 25.
REQ-025 WAIT_DONE: dcm_progen_o=0; a 16-bit cycle counter runs from 0.
  - Move to FINISH on the first cycle dcm_progdone_i=1 and dcm_locked_i=1.
  - If the counter reaches TIMEOUT first: set error_o, clear busy_o, return to IDLE, leave mul_o/div_o unchanged.
REQ-026 FINISH (1 cycle): pulse done_o, copy the latched values to mul_o/div_o, clear busy_o, return to IDLE.
REQ-027 dcm_progdone_i asserted outside WAIT_DONE is ignored.
REQ-028 All outputs are registered; dcm_progen_o and dcm_progdata_o change only on rising clk_i.
REQ-029 The bit counter is 4 bits and the timeout counter is 16 bits; neither wraps inside a state.

Reset
REQ-030 reset_n_i low, asynchronously:
  - state=IDLE; dcm_progen_o=0, dcm_progdata_o=0, busy_o=0, done_o=0, error_o=0;
  - mul_o=8'd1 and div_o=8'd0, matching the power-on M=2/D=1;
  - counters=0.
REQ-031 Reset during any programming state aborts immediately with dcm_progen_o=0; no partial values reach mul_o/div_o.
REQ-032 After reset release, the first load_i is accepted on the first rising edge with reset_n_i high.

Verification
REQ-033 mul_i=8'd3, div_i=8'd1, load_i pulse, progdone returned 5 cycles after GO:
  - PROGDATA cycles 1-10 = 1,0,1,0,0,0,0,0,0,0;
  - cycles 13-22 = 1,1,1,1,0,0,0,0,0,0;
  - GO at cycle 25, done_o one pulse, mul_o=3, div_o=1, error_o=0.
REQ-034 mul_i=0, load_i -> error_o=1 next cycle, dcm_progen_o stays 0, busy_o stays 0, mul_o=1.
REQ-035 TIMEOUT=100, dcm_progdone_i held 0 -> error_o=1 and busy_o=0 exactly 100 cycles after WAIT_DONE entry; mul_o/div_o unchanged; a following valid load clears error_o.
REQ-036 Second load_i at cycle 5 with different values -> bitstream and final mul_o/div_o equal the first request.
REQ-037 reset_n_i low at cycle 15 (inside LOAD_M) -> dcm_progen_o=0 without a clock edge, state IDLE, mul_o=1, div_o=0.
REQ-038 dcm_progdone_i=1 with dcm_locked_i=0 in WAIT_DONE -> no done_o; dcm_locked_i rising 3 cycles later -> done_o pulse on the following cycle.
